register_pipeline: RTL and testbench

REGISTER_PIPELINE -- requirements
Module: register_pipeline

---
 rtl/register_pkg.sv | 12 +
 rtl/register_stage.sv | 46 ++++
 rtl/register_pipeline.sv | 86 ++++++++
 tb/tb_register_pipeline.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// Shared defaults and helpers for the register pipeline.
package register_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 3;

    // Bits needed to count 0..depth valid stages.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/register_stage.sv
// One pipeline stage: a valid bit plus a data register with load/hold and clear.
module register_stage #(
    parameter int unsigned         WIDTH       = 8,
    parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d,  data_q;

    // Clear wins over load; otherwise hold so data only changes when the stage loads.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = RESET_VALUE;
        end else if (load_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/register_pipeline.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapse,
// global clock enable and synchronous flush.
module register_pipeline
    import register_pkg::*;
#(
    parameter int unsigned      WIDTH       = DefaultWidth,
    parameter int unsigned      DEPTH       = DefaultDepth,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clock_enable,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(DEPTH)-1:0]    occupancy
);

    localparam int unsigned OccWidth = occ_width(DEPTH);

    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_ready;
    logic [DEPTH-1:0] prev_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [WIDTH-1:0] prev_data  [DEPTH];
    logic             advance;
    logic             clear;
    logic             hole;
    logic [OccWidth-1:0] occ_count;

    assign advance = clock_enable & ~flush;
    assign clear   = clock_enable & flush;

    // A stage is ready iff out_ready or some stage at or after it is empty; written as a
    // running OR from the output end so there is no combinational self-loop on the vector.
    always_comb begin
        hole        = 1'b0;
        stage_ready = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            hole           = hole | ~stage_valid[k];
            stage_ready[k] = hole | out_ready;
        end
    end

    // Occupancy is a popcount of the registered valid bits.
    always_comb begin
        occ_count = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ_count = occ_count + OccWidth'(stage_valid[k]);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign prev_valid[k] = in_valid;
            assign prev_data[k]  = in_data;
        end else begin : g_body
            assign prev_valid[k] = stage_valid[k-1];
            assign prev_data[k]  = stage_data[k-1];
        end

        register_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clock_i (clock),
            .reset_i (reset),
            .clear_i (clear),
            .load_i  (advance & stage_ready[k]),
            .valid_i (prev_valid[k]),
            .data_i  (prev_data[k]),
            .valid_o (stage_valid[k]),
            .data_o  (stage_data[k])
        );
    end

    assign in_ready  = stage_ready[0] & advance;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];
    assign occupancy = occ_count;

endmodule

// File: tb/tb_register_pipeline.sv
// Directed bench for register_pipeline (WIDTH=8, DEPTH=3, RESET_VALUE=0xC3).
module tb_register_pipeline;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 3;
    localparam logic [7:0]  RV = 8'hC3;

    logic       clock = 1'b0;
    logic       reset;
    logic       clock_enable;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    int tests_run    = 0;
    int tests_failed = 0;

    register_pipeline #(
        .WIDTH       (W),
        .DEPTH       (D),
        .RESET_VALUE (RV)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clock_enable (clock_enable),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy)
    );

    always #5 clock = ~clock;

    // Advance one edge; drive and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clock_enable = 1'b0; flush = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        tick();
        reset = 1'b0; clock_enable = 1'b1; flush = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        tests_run++;
        if (out_data !== RV) begin
            tests_failed++; $display("FAIL reset_out_data got %h want %h", out_data, RV);
        end
        tests_run++;
        if (occupancy !== 2'd0) begin
            tests_failed++; $display("FAIL reset_occupancy got %0d want 0", occupancy);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        clock_enable = 1'b0; #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL ce_low_in_ready got %b want 0", in_ready);
        end
        clock_enable = 1'b1; flush = 1'b1; #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL flush_in_ready got %b want 0", in_ready);
        end
        flush = 1'b0;
    endtask

    task automatic test_streaming();
        logic [7:0] exp_out [3];
        exp_out[0] = 8'h11; exp_out[1] = 8'h22; exp_out[2] = 8'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = exp_out[i]; #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready);
            end
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL stream_early_valid[%0d] got %b want 0", i, out_valid);
            end
            tick();
        end
        in_valid = 1'b0; #1;
        tests_run++;
        if (occupancy !== 2'd3) begin
            tests_failed++; $display("FAIL stream_occupancy got %0d want 3", occupancy);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_out[i]) begin
                tests_failed++;
                $display("FAIL stream_out[%0d] got v=%b d=%h want v=1 d=%h",
                         i, out_valid, out_data, exp_out[i]);
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            tests_failed++;
            $display("FAIL stream_drained got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_out [4];
        exp_out[0] = 8'hA1; exp_out[1] = 8'hA2; exp_out[2] = 8'hA3; exp_out[3] = 8'hA4;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = exp_out[i]; #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++; $display("FAIL bp_accept[%0d] got %b want 1", i, in_ready);
            end
            tick();
        end
        in_data = exp_out[3]; #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL bp_full_in_ready got %b want 0", in_ready);
        end
        tests_run++;
        if (occupancy !== 2'd3) begin
            tests_failed++; $display("FAIL bp_occupancy got %0d want 3", occupancy);
        end
        tick();
        tests_run++;
        if (out_data !== 8'hA1 || occupancy !== 2'd3) begin
            tests_failed++;
            $display("FAIL bp_stall_hold got d=%h occ=%0d want d=a1 occ=3", out_data, occupancy);
        end
        // Full and out_ready=1 must accept in the same cycle.
        out_ready = 1'b1; #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_full_passthrough got %b want 1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_out[i]) begin
                tests_failed++;
                $display("FAIL bp_out[%0d] got v=%b d=%h want v=1 d=%h",
                         i, out_valid, out_data, exp_out[i]);
            end
            tick();
            in_valid = 1'b0; #1;
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_drained got %b want 0", out_valid);
        end
    endtask

    task automatic test_bubble_collapse();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || occupancy !== 2'd1) begin
            tests_failed++;
            $display("FAIL bubble_tail got v=%b d=%h occ=%0d want v=1 d=5a occ=1",
                     out_valid, out_data, occupancy);
        end
        in_valid = 1'b1; in_data = 8'h01;
        tick();
        in_data = 8'h02; #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bubble_accept got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0; #1;
        tests_run++;
        if (occupancy !== 2'd3 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_full got occ=%0d rdy=%b want occ=3 rdy=0", occupancy, in_ready);
        end
        out_ready = 1'b1;
        tests_run++;
        if (out_data !== 8'h5A) begin
            tests_failed++; $display("FAIL bubble_out0 got %h want 5a", out_data);
        end
        tick();
        tests_run++;
        if (out_data !== 8'h01) begin
            tests_failed++; $display("FAIL bubble_out1 got %h want 01", out_data);
        end
        tick();
        tests_run++;
        if (out_data !== 8'h02) begin
            tests_failed++; $display("FAIL bubble_out2 got %h want 02", out_data);
        end
        tick();
    endtask

    task automatic test_enable_hold();
        logic [7:0] exp_out [4];
        exp_out[0] = 8'hB1; exp_out[1] = 8'hB2; exp_out[2] = 8'hB3; exp_out[3] = 8'hB4;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = exp_out[i];
            tick();
        end
        clock_enable = 1'b0; in_data = exp_out[3];
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0 || occupancy !== 2'd3 || out_valid !== 1'b1
                || out_data !== 8'hB1) begin
                tests_failed++;
                $display("FAIL hold[%0d] got rdy=%b occ=%0d v=%b d=%h want rdy=0 occ=3 v=1 d=b1",
                         i, in_ready, occupancy, out_valid, out_data);
            end
            tick();
        end
        clock_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_out[i]) begin
                tests_failed++;
                $display("FAIL resume_out[%0d] got v=%b d=%h want v=1 d=%h",
                         i, out_valid, out_data, exp_out[i]);
            end
            tick();
            in_valid = 1'b0;
        end
        #1;
        tests_run++;
        if (occupancy !== 2'd0) begin
            tests_failed++; $display("FAIL resume_drained got %0d want 0", occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hC1;
        tick();
        in_data = 8'hC2;
        tick();
        tests_run++;
        if (occupancy !== 2'd2) begin
            tests_failed++; $display("FAIL flush_pre_occ got %0d want 2", occupancy);
        end
        flush = 1'b1; in_data = 8'h77; #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL flush_in_ready got %b want 0", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
        tests_run++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== RV) begin
            tests_failed++;
            $display("FAIL flush_clear got occ=%0d v=%b d=%h want occ=0 v=0 d=%h",
                     occupancy, out_valid, out_data, RV);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL flush_ghost[%0d] got v=%b d=%h want v=0",
                                         i, out_valid, out_data);
            end
        end
        // Flush with clock_enable low must do nothing.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hD1;
        tick();
        in_valid = 1'b0; clock_enable = 1'b0; flush = 1'b1;
        tick();
        clock_enable = 1'b1; flush = 1'b0; #1;
        tests_run++;
        if (occupancy !== 2'd1) begin
            tests_failed++; $display("FAIL flush_no_ce got occ=%0d want 1", occupancy);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hE1; tick();
        in_data = 8'hE2; tick();
        #1;
        tests_run++;
        if (occupancy !== 2'd3) begin
            tests_failed++; $display("FAIL rst_mid_pre_occ got %0d want 3", occupancy);
        end
        in_valid = 1'b0; reset = 1'b1; clock_enable = 1'b0;
        tick();
        reset = 1'b0; clock_enable = 1'b1; #1;
        tests_run++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== RV) begin
            tests_failed++;
            $display("FAIL rst_mid got occ=%0d v=%b d=%h want occ=0 v=0 d=%h",
                     occupancy, out_valid, out_data, RV);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_enable_hold();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
